// File: rtl/risc4_ctrl_if.sv
// risc4_ctrl_if: bus bundle between the risc4 controller, program ROM, ALU and debug port.
// Parameter: PC_W program counter / ROM address width.
// Signals: start pulse, imem_addr/imem_data ROM port, alu_a/alu_b/alu_opn ALU drive,
//   alu_out0/alu_out1/alu_status registered ALU results, busy/halted/carry status,
//   dbg_sel/dbg_data register-file peek.
// master = controller side, slave = environment side.
interface risc4_ctrl_if #(parameter int PC_W = 4);
   logic            start;
   logic [PC_W-1:0] imem_addr;
   logic [11:0]     imem_data;
   logic [3:0]      alu_a;
   logic [3:0]      alu_b;
   logic [2:0]      alu_opn;
   logic [3:0]      alu_out0;
   logic [3:0]      alu_out1;
   logic [3:0]      alu_status;
   logic            busy;
   logic            halted;
   logic            carry;
   logic [1:0]      dbg_sel;
   logic [3:0]      dbg_data;
   modport master (
      input  start, imem_data, alu_out0, alu_out1, alu_status, dbg_sel,
      output imem_addr, alu_a, alu_b, alu_opn, busy, halted, carry, dbg_data
   );
   modport slave (
      output start, imem_data, alu_out0, alu_out1, alu_status, dbg_sel,
      input  imem_addr, alu_a, alu_b, alu_opn, busy, halted, carry, dbg_data
   );
endinterface

// File: rtl/risc4_ctrl.sv
// risc4_ctrl: multi-cycle fetch/decode/execute/writeback sequencer driving the 4-bit ALU.
// Ports: clk, rst (synchronous, active-high), bus (risc4_ctrl_if.master) carrying the
//   start pulse, ROM address/data, ALU operands/opcode/results, busy/halted/carry and debug read.
// Optional feature: define RISC4_BRANCH_EN to decode op 9 as BRLT using the LT flag;
//   otherwise op 9 is a NOP and the LT flag register does not exist.
module risc4_ctrl #(
   parameter int PC_W = 4
) (
   input logic          clk,
   input logic          rst,
   risc4_ctrl_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
   state_t          r_state, w_next;
   logic [PC_W-1:0] r_pc, w_pc_nxt;
   logic [11:0]     r_ir;
   logic [3:0]      r_regs [4];
   logic            r_carry;
   logic [3:0]      w_op, w_imm;
   logic [1:0]      w_rd, w_rs, w_rt;
   logic            w_alu, w_exec_alu, w_take, w_unused;
   assign w_op       = r_ir[11:8];
   assign w_rd       = r_ir[7:6];
   assign w_rs       = r_ir[5:4];
   assign w_imm      = r_ir[3:0];
   assign w_rt       = w_imm[1:0];
   assign w_alu      = w_op < 4'd7;
   assign w_exec_alu = (r_state == S_EXEC) && w_alu;
`ifdef RISC4_BRANCH_EN
   logic r_lt;
   always_ff @(posedge clk) begin
      if (rst) r_lt <= 1'b0;
      else if (r_state == S_WB && w_op == 4'd6) r_lt <= bus.alu_status[2];
   end
   assign w_take   = (w_op == 4'h8) || (w_op == 4'h9 && r_lt);
   assign w_unused = ^{bus.alu_status[3], bus.alu_status[0]};
`else
   assign w_take   = w_op == 4'h8;
   assign w_unused = ^{bus.alu_status[3], bus.alu_status[2], bus.alu_status[0]};
`endif
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next   = r_state;
      w_pc_nxt = r_pc;
      case (r_state)
         S_IDLE: begin
            w_next   = bus.start ? S_FETCH : S_IDLE;
            w_pc_nxt = bus.start ? '0 : r_pc;
         end
         S_FETCH:  w_next = S_DECODE;
         S_DECODE: w_next = S_EXEC;
         S_EXEC: begin
            w_next   = w_alu ? S_WB : (w_op == 4'hF ? S_HALT : S_FETCH);
            // ALU ops advance pc in WB; HALT freezes pc on its own address
            w_pc_nxt = (w_alu || w_op == 4'hF) ? r_pc : (w_take ? PC_W'(w_imm) : r_pc + PC_W'(1));
         end
         S_WB: begin
            w_next   = S_FETCH;
            w_pc_nxt = r_pc + PC_W'(1);
         end
         default: ;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= '0;
         r_ir    <= '0;
         r_carry <= 1'b0;
         r_regs  <= '{default: '0};
      end else begin
         r_pc <= w_pc_nxt;
         if (r_state == S_DECODE) r_ir <= bus.imem_data;
         if (r_state == S_EXEC && w_op == 4'h7) r_regs[w_rd] <= w_imm;
         if (r_state == S_WB) begin
            if (w_op != 4'd6) r_regs[w_rd] <= bus.alu_out0;
            // high half of MUL goes to the next register; later write takes priority
            if (w_op == 4'd2) r_regs[w_rd + 2'd1] <= bus.alu_out1;
            if (w_op <= 4'd1) r_carry <= bus.alu_status[1];
         end
      end
   end
   assign bus.imem_addr = r_pc;
   assign bus.alu_a     = w_exec_alu ? r_regs[w_rs] : 4'd0;
   assign bus.alu_b     = w_exec_alu ? r_regs[w_rt] : 4'd0;
   assign bus.alu_opn   = w_exec_alu ? w_op[2:0] : 3'b111;
   assign bus.busy      = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_WB);
   assign bus.halted    = r_state == S_HALT;
   assign bus.carry     = r_carry;
   assign bus.dbg_data  = r_regs[bus.dbg_sel];
endmodule

// File: tb/tb_risc4_ctrl.sv
// tb_risc4_ctrl: self-checking bench for risc4_ctrl with ROM/ALU models and an ISA-level reference interpreter.
module tb_risc4_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [11:0] rom [16];
   logic [7:0]  alu_r;
`ifdef RISC4_BRANCH_EN
   localparam bit BR = 1'b1;
`else
   localparam bit BR = 1'b0;
`endif
   int m_regs [4];
   int m_carry, m_cyc, m_halt;

   risc4_ctrl_if #(.PC_W(4)) bus ();
   risc4_ctrl #(.PC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

   always_comb begin
      alu_r = 8'd0;
      case (bus.alu_opn)
         3'd0: alu_r = {4'd0, bus.alu_a} + {4'd0, bus.alu_b};
         3'd1: alu_r = {4'd0, bus.alu_a} - {4'd0, bus.alu_b};
         3'd2: alu_r = {4'd0, bus.alu_a} * {4'd0, bus.alu_b};
         3'd3: alu_r = {4'd0, bus.alu_a & bus.alu_b};
         3'd4: alu_r = {4'd0, bus.alu_a | bus.alu_b};
         3'd5: alu_r = {4'd0, bus.alu_a ^ bus.alu_b};
         default: ;
      endcase
   end

   always @(posedge clk) begin
      if (bus.alu_opn != 3'b111) begin
         bus.alu_out0   <= alu_r[3:0];
         bus.alu_out1   <= alu_r[7:4];
         bus.alu_status <= {1'b0, bus.alu_a < bus.alu_b, alu_r[4], alu_r[3:0] == 4'd0};
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ISA-level interpreter: walks the program from pc 0 and sums per-instruction latencies
   task automatic model_run();
      int pc, lt, a, b, op, rd, rs, rt, imm;
      logic [11:0] w;
      pc = 0; lt = 0; m_cyc = 0; m_halt = 0; m_carry = 0;
      m_regs = '{0, 0, 0, 0};
      for (int n = 0; n < 200 && m_halt == 0; n++) begin
         w = rom[pc];
         op = int'(w[11:8]); rd = int'(w[7:6]); rs = int'(w[5:4]); imm = int'(w[3:0]); rt = imm % 4;
         a = m_regs[rs]; b = m_regs[rt];
         if (op <= 6) begin
            m_cyc += 4;
            case (op)
               0: begin m_carry = (a + b > 15) ? 1 : 0; m_regs[rd] = (a + b) % 16; end
               1: begin m_carry = (a < b) ? 1 : 0; m_regs[rd] = (a - b + 16) % 16; end
               2: begin m_regs[rd] = (a * b) % 16; m_regs[(rd + 1) % 4] = (a * b) / 16; end
               3: m_regs[rd] = a & b;
               4: m_regs[rd] = a | b;
               5: m_regs[rd] = a ^ b;
               default: lt = (a < b) ? 1 : 0;
            endcase
            pc = (pc + 1) % 16;
         end else begin
            m_cyc += 3;
            if (op == 15) m_halt = 1;
            else if (op == 7) begin m_regs[rd] = imm; pc = (pc + 1) % 16; end
            else if (op == 8 || (op == 9 && BR && lt != 0)) pc = imm;
            else pc = (pc + 1) % 16;
         end
      end
   endtask

   task automatic do_reset();
      bus.start = 1'b0;
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic read_reg(input int i, output logic [3:0] v);
      bus.dbg_sel = 2'(i);
      #1 v = bus.dbg_data;
   endtask

   // pulse start, then count cycles from busy rising until halted (bounded)
   task automatic run_prog(output int cyc);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      cyc = 0;
      while (!bus.halted && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic load_add();
      rom = '{default: 12'hF00};
      rom[0] = 12'h705; rom[1] = 12'h743; rom[2] = 12'h081; rom[3] = 12'hF00;
   endtask

   task automatic test_reset();
      logic [3:0] v;
      do_reset();
      n_tests++; if (bus.imem_addr !== 4'd0) begin n_fail++; $display("FAIL reset_imem_addr got %h want 0", bus.imem_addr); end
      n_tests++; if (bus.alu_a !== 4'd0 || bus.alu_b !== 4'd0) begin n_fail++; $display("FAIL reset_alu_ab got %h/%h want 0/0", bus.alu_a, bus.alu_b); end
      n_tests++; if (bus.alu_opn !== 3'b111) begin n_fail++; $display("FAIL reset_alu_opn got %b want 111", bus.alu_opn); end
      n_tests++; if ({bus.busy, bus.halted, bus.carry} !== 3'b000) begin n_fail++; $display("FAIL reset_flags busy/halted/carry got %b want 000", {bus.busy, bus.halted, bus.carry}); end
      for (int i = 0; i < 4; i++) begin
         read_reg(i, v);
         n_tests++; if (v !== 4'd0) begin n_fail++; $display("FAIL reset_reg%0d got %h want 0", i, v); end
      end
   endtask

   task automatic test_add();
      int cyc;
      logic [3:0] v;
      load_add(); do_reset(); model_run(); run_prog(cyc);
      n_tests++; if (cyc != 13) begin n_fail++; $display("FAIL add_latency got %0d want 13", cyc); end
      n_tests++; if (cyc != m_cyc) begin n_fail++; $display("FAIL add_model_latency got %0d want %0d", cyc, m_cyc); end
      read_reg(2, v);
      n_tests++; if (v !== 4'd8) begin n_fail++; $display("FAIL add_r2 got %h want 8", v); end
      n_tests++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL add_carry got %b want 0", bus.carry); end
      n_tests++; if (bus.busy !== 1'b0 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL add_halt busy/halted got %b%b want 01", bus.busy, bus.halted); end
   endtask

   task automatic test_mul();
      int cyc;
      logic [3:0] v2, v3;
      rom = '{default: 12'hF00};
      rom[0] = 12'h706; rom[1] = 12'h747; rom[2] = 12'h281;
      do_reset(); run_prog(cyc);
      read_reg(2, v2); read_reg(3, v3);
      n_tests++; if (v2 !== 4'hA || v3 !== 4'h2) begin n_fail++; $display("FAIL mul_r2r3 got %h/%h want a/2", v2, v3); end
   endtask

   task automatic test_sub();
      int cyc;
      logic [3:0] v;
      rom = '{default: 12'hF00};
      rom[0] = 12'h703; rom[1] = 12'h745; rom[2] = 12'h181;
      do_reset(); run_prog(cyc);
      read_reg(2, v);
      n_tests++; if (v !== 4'hE) begin n_fail++; $display("FAIL sub_r2 got %h want e", v); end
      n_tests++; if (bus.carry !== 1'b1) begin n_fail++; $display("FAIL sub_borrow got %b want 1", bus.carry); end
   endtask

   task automatic test_branch();
      int cyc;
      logic [3:0] v, want;
      rom = '{default: 12'hF00};
      rom[0] = 12'h702; rom[1] = 12'h749; rom[2] = 12'h601; rom[3] = 12'h906;
      rom[4] = 12'h781; rom[5] = 12'hA00; rom[6] = 12'hF00;
      want = BR ? 4'd0 : 4'd1;
      do_reset(); model_run(); run_prog(cyc);
      read_reg(2, v);
      n_tests++; if (v !== want) begin n_fail++; $display("FAIL branch_r2 got %h want %h", v, want); end
      n_tests++; if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL branch_halted got %b want 1", bus.halted); end
      n_tests++; if (cyc != m_cyc) begin n_fail++; $display("FAIL branch_latency got %0d want %0d", cyc, m_cyc); end
   endtask

   task automatic test_wrap();
      int drops, seen;
      logic [3:0] prev;
      rom = '{default: 12'hA00};
      do_reset();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      drops = 0; seen = 0; prev = bus.imem_addr;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (!bus.busy) drops++;
         if (prev == 4'd15 && bus.imem_addr == 4'd0) seen = 1;
         prev = bus.imem_addr;
      end
      n_tests++; if (seen != 1) begin n_fail++; $display("FAIL wrap_pc got seen=%0d want 1", seen); end
      n_tests++; if (drops != 0) begin n_fail++; $display("FAIL wrap_busy low_cycles got %0d want 0", drops); end
   endtask

   task automatic test_reset_wb();
      int n;
      logic [3:0] v;
      load_add(); do_reset();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      n = 0;
      while (bus.alu_opn === 3'b111 && n < 50) begin @(negedge clk); n++; end
      n_tests++; if (bus.alu_opn !== 3'd0 || bus.alu_a !== 4'd5 || bus.alu_b !== 4'd3) begin n_fail++; $display("FAIL exec_drive opn/a/b got %b/%h/%h want 000/5/3", bus.alu_opn, bus.alu_a, bus.alu_b); end
      @(negedge clk);
      n_tests++; if (bus.alu_opn !== 3'b111) begin n_fail++; $display("FAIL wb_opn got %b want 111", bus.alu_opn); end
      rst = 1'b1;
      @(negedge clk);
      read_reg(2, v);
      n_tests++; if (v !== 4'd0) begin n_fail++; $display("FAIL rstwb_r2 got %h want 0", v); end
      n_tests++; if (bus.imem_addr !== 4'd0 || bus.alu_opn !== 3'b111 || bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.carry !== 1'b0) begin
         n_fail++; $display("FAIL rstwb_outputs addr/opn/busy/halted/carry got %h/%b/%b/%b/%b want 0/111/0/0/0", bus.imem_addr, bus.alu_opn, bus.busy, bus.halted, bus.carry);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstwb_idle busy got %b want 0", bus.busy); end
   endtask

   task automatic test_start_ignored();
      int cyc;
      logic [3:0] v;
      load_add(); do_reset();
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      cyc = 0;
      while (!bus.halted && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         bus.start = (cyc == 5);
      end
      bus.start = 1'b0;
      n_tests++; if (cyc != 13) begin n_fail++; $display("FAIL start_mid latency got %0d want 13", cyc); end
      read_reg(2, v);
      n_tests++; if (v !== 4'd8) begin n_fail++; $display("FAIL start_mid_r2 got %h want 8", v); end
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      repeat (4) @(negedge clk);
      n_tests++; if (bus.halted !== 1'b1 || bus.busy !== 1'b0 || bus.imem_addr !== 4'd3) begin
         n_fail++; $display("FAIL start_halt halted/busy/addr got %b/%b/%h want 1/0/3", bus.halted, bus.busy, bus.imem_addr);
      end
   endtask

   task automatic test_random();
      int cyc;
      logic [11:0] w;
      logic [3:0] v;
      for (int p = 0; p < 25; p++) begin
         for (int a = 0; a < 15; a++) begin
            w = 12'($urandom_range(0, 4095));
            if (w[11:8] == 4'h8 || w[11:8] == 4'h9) w[3:0] = 4'($urandom_range(a + 1, 15));
            if (w[11:8] == 4'hF && $urandom_range(0, 3) != 0) w[11:8] = 4'h7;
            rom[a] = w;
         end
         rom[15] = 12'hF00;
         do_reset(); model_run(); run_prog(cyc);
         n_tests++; if (cyc != m_cyc) begin n_fail++; $display("FAIL rand%0d_latency got %0d want %0d", p, cyc, m_cyc); end
         n_tests++; if (bus.carry !== m_carry[0]) begin n_fail++; $display("FAIL rand%0d_carry got %b want %0d", p, bus.carry, m_carry); end
         for (int i = 0; i < 4; i++) begin
            read_reg(i, v);
            n_tests++; if (v !== 4'(m_regs[i])) begin n_fail++; $display("FAIL rand%0d_reg%0d got %h want %h", p, i, v, 4'(m_regs[i])); end
         end
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.dbg_sel = 2'd0;
      test_reset();
      test_add();
      test_mul();
      test_sub();
      test_branch();
      test_wrap();
      test_reset_wb();
      test_start_ignored();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/risc4_ctrl.md
# risc4_ctrl

Sequencing controller sitting directly upstream of the 4-bit ALU in the risc-iv datapath. It fetches 12-bit instructions from a synchronous program ROM and decodes them. It reads a four-entry 4-bit register file, drives the ALU's operand and opcode inputs, then writes the ALU's registered results back into the register file. Program flow is handled by a multi-cycle FSM supporting immediate load, jump, conditional branch and halt.

## Interface
- `PC_W`, default 4: program counter width; ROM depth is 2^PC_W.
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle pulse; begins execution at pc 0 from IDLE.
- `imem_addr`, output, PC_W: ROM address.
- `imem_data`, input, 12: ROM word; valid one cycle after `imem_addr`.
- `alu_a`, output, 4: ALU operand a.
- `alu_b`, output, 4: ALU operand b.
- `alu_opn`, output, 3: ALU opcode; 3'b111 = no-op (ALU holds its outputs).
- `alu_out0`, input, 4: ALU low result, registered in the ALU.
- `alu_out1`, input, 4: ALU high result (MUL only).
- `alu_status`, input, 4: ALU flags; [1] carry/borrow, [2] less-than.
- `busy`, output, 1: high from `start` acceptance until HALT.
- `halted`, output, 1: high in HALT state.
- `carry`, output, 1: last captured carry/borrow.
- `dbg_sel`, input, 2: register-file read select.
- `dbg_data`, output, 4: combinational read of `regs[dbg_sel]`.

## Operation
- Instruction fields: op = [11:8], rd = [7:6], rs = [5:4], imm = [3:0]; rt = imm[1:0].
- op 0–6 (ALU): `alu_opn` = op[2:0], `alu_a` = regs[rs], `alu_b` = regs[rt].
  - Op encoding: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 LT.
  - Writeback for ADD/SUB/AND/OR/XOR: regs[rd] <= alu_out0.
  - Writeback for MUL: regs[rd] <= alu_out0 and regs[(rd+1) mod 4] <= alu_out1. The second write wins if it aliases.
  - ADD/SUB additionally set `carry` <= alu_status[1].
  - LT writes no register; it sets internal `lt_flag` <= alu_status[2].
- op 7 LDI: regs[rd] <= imm.
- op 8 JMP: pc <= imm, zero-extended to PC_W.
- op 9 BRLT: if `lt_flag`, pc <= imm; else pc+1 (see Configuration).
- op A–E: NOP.
- op F: HALT.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: waits for `start`; on start, pc <= 0 and go to FETCH. `start` outside IDLE is ignored.
  - FETCH: `imem_addr` = pc; go to DECODE.
  - DECODE: latch `imem_data` into the instruction register; go to EXEC.
  - EXEC, ALU op: drive a/b/opn for exactly this cycle; go to WB.
  - EXEC, non-ALU op: perform the op, update pc, go to FETCH (or to HALT for HALT).
  - WB: sample alu_out0/alu_out1/alu_status, write the register file, pc <= pc+1, go to FETCH.
  - HALT: held until `rst`; `start` is ignored.
- `alu_opn` = 3'b111 in every state except EXEC with an ALU op.
- pc increments modulo 2^PC_W: 15 -> 0 with no error.
- All arithmetic results come from the ALU; the controller only adds the pc increment.

## Timing
- Reset values:
  - pc, `imem_addr`, `alu_a`, `alu_b`: 0.
  - `alu_opn`: 3'b111.
  - `busy`, `halted`, `carry`, `lt_flag`: 0.
  - All regs: 0.
  - State: IDLE.
- Reset mid-instruction aborts the instruction with no register write; all reset values appear the cycle after the `rst` edge.
- Instruction latency:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LDI/JMP/BRLT/NOP: 3 cycles.
  - HALT: 3 cycles to reach the HALT state.
- `busy` rises the cycle after `start` is sampled, and falls on entry to HALT, together with `halted` rising.
- The ALU registers its result on the EXEC->WB edge; the controller consumes it in WB, with no extra wait state.
- A register written in WB is visible to the following instruction's EXEC; no forwarding is needed.

## Configuration
- `RISC4_BRANCH_EN` defined: BRLT is decoded as specified above.
- `RISC4_BRANCH_EN` undefined: op 9 is a NOP (pc+1) and the `lt_flag` register is removed. LT still executes on the ALU but its flag is discarded.

## Test plan
- Reset, then `start`; program LDI r0,5 / LDI r1,3 / ADD r2,r0,r1 / HALT.
  - Required: r2 = 8 and carry = 0.
  - `halted` rises 13 cycles after `busy` rises (3 + 3 + 4 + 3 cycles).
- LDI r0,6 / LDI r1,7 / MUL r2,r0,r1.
  - Required: r2 = 0xA, r3 = 0x2.
- LDI r0,3 / LDI r1,5 / SUB r2,r0,r1.
  - Required: r2 = 0xE, carry = 1.
- With `RISC4_BRANCH_EN`: LDI r0,2 / LDI r1,9 / LT r0,r1 / BRLT 6 at addr 3, LDI r2,1 at 4, HALT at 6.
  - Required: r2 stays 0 and HALT is reached.
  - With the macro undefined, the same program gives r2 = 1.
- A ROM of 16 NOPs.
  - Required: pc wraps 15 -> 0 and `busy` stays high.
- Assert `rst` during WB of an ADD.
  - Required: destination stays 0; state, pc and all outputs equal their reset values the next cycle.
- `start` pulsed during execution and during HALT.
  - Required: no effect in either case.
